// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side controller: state type and depth helpers.
package fifo_pkg;

  // Default address width; the FIFO holds 2**K words.
  localparam int unsigned DEF_K = 4;
  localparam int unsigned DEPTH = 2 ** DEF_K;

  // Occupancy state of the write side.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Number of words addressed by a k-bit pointer.
  function automatic int unsigned depth_of(input int unsigned k);
    return 2 ** k;
  endfunction

endpackage

// File: rtl/write_counter.sv
// K-bit write pointer; advances by one on each enabled cycle and wraps silently.
module write_counter #(
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [K-1:0] ptr
);

  // Pointer register: natural K-bit wrap from 2**K-1 back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + K'(1);
    end
  end

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side FIFO controller: accepts write requests, drives the RAM write port one
// cycle later, tracks occupancy against read-side consume pulses and raises
// full / almost_full / overflow.
// Optional build macro FIFO_WR_OVF_STICKY_EN makes overflow sticky until reset;
// without it overflow pulses for one cycle per rejected request.
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned K         = DEF_K,
  parameter int unsigned W         = 8,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_req,
  input  logic [W-1:0] wr_data,
  input  logic         rd_inc,
  output logic         ram_we,
  output logic [K-1:0] ram_waddr,
  output logic [W-1:0] ram_wdata,
  output logic [K:0]   count,
  output logic         full,
  output logic         almost_full,
  output logic         overflow
);

  localparam logic [K:0] FULL_CNT = (K+1)'(depth_of(K));
  localparam logic [K:0] AF_LIM   = (K+1)'(AF_MARGIN);

  state_t       state;
  logic [K-1:0] wr_ptr;
  logic         acc;
  logic         dec;
  logic [K:0]   next_count;

  // Accept uses the registered full, so a read in the same cycle cannot make room.
  assign acc = wr_req & ~full;
  assign dec = rd_inc & (count != '0);

  write_counter #(.K(K)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (acc),
    .ptr (wr_ptr)
  );

  // Next occupancy: a simultaneous write and consume cancel out.
  always_comb begin
    next_count = count;
    if (acc && !dec) begin
      next_count = count + (K+1)'(1);
    end else if (dec && !acc) begin
      next_count = count - (K+1)'(1);
    end
  end

  // RAM write port, one cycle behind the accepted request; addr/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= acc;
      if (acc) begin
        ram_waddr <= wr_ptr;
        ram_wdata <= wr_data;
      end
    end
  end

  // Occupancy FSM plus count and level flags registered from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= next_count;
      full        <= (next_count == FULL_CNT);
      almost_full <= ((FULL_CNT - next_count) <= AF_LIM);
      case (state)
        EMPTY: begin
          if (acc) begin
            state <= FILLING;
          end
        end
        FILLING: begin
          if ((count == FULL_CNT - (K+1)'(1)) && acc && !dec) begin
            state <= FULL;
          end else if ((count == (K+1)'(1)) && dec && !acc) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (rd_inc) begin
            state <= FILLING;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // Overflow flags a write request that arrived while the FIFO was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
`ifdef FIFO_WR_OVF_STICKY_EN
      if (wr_req && full) begin
        overflow <= 1'b1;
      end
`else
      overflow <= wr_req & full;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl (K=4, W=8, AF_MARGIN=2).
// Honors FIFO_WR_OVF_STICKY_EN when defined for the build.
module tb_fifo_write_ctrl;

  localparam int K     = 4;
  localparam int W     = 8;
  localparam int AFM   = 2;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst;
  logic         wr_req;
  logic [W-1:0] wr_data;
  logic         rd_inc;
  logic         ram_we;
  logic [K-1:0] ram_waddr;
  logic [W-1:0] ram_wdata;
  logic [K:0]   count;
  logic         full;
  logic         almost_full;
  logic         overflow;

  int nvec;
  int nerr;

  // Reference model state
  int m_count;
  int m_ptr;
  int m_addr;
  int m_data;
  int m_we;
  int m_ovf;

  fifo_write_ctrl #(.K(K), .W(W), .AF_MARGIN(AFM)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_inc      (rd_inc),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_count = 0;
    m_ptr   = 0;
    m_addr  = 0;
    m_data  = 0;
    m_we    = 0;
    m_ovf   = 0;
  endtask

  // Compare every output against the model
  task automatic checkOutput(input string tag);
    cmp({tag, ".we"},    int'(ram_we),      m_we);
    cmp({tag, ".addr"},  int'(ram_waddr),   m_addr);
    cmp({tag, ".data"},  int'(ram_wdata),   m_data);
    cmp({tag, ".count"}, int'(count),       m_count);
    cmp({tag, ".full"},  int'(full),        int'(m_count == DEPTH));
    cmp({tag, ".af"},    int'(almost_full), int'((DEPTH - m_count) <= AFM));
    cmp({tag, ".ovf"},   int'(overflow),    m_ovf);
  endtask

  // One clock of stimulus; the model advances on the same edge from its pre-edge state
  task automatic applyStimulus(input string tag, input logic req, input logic [W-1:0] data,
                               input logic rdi);
    bit was_full;
    bit acc;
    bit dec;
    @(negedge clk);
    wr_req  = req;
    wr_data = data;
    rd_inc  = rdi;
    @(posedge clk);
    was_full = (m_count == DEPTH);
    acc      = req && !was_full;
    dec      = rdi && (m_count > 0);
    m_we     = acc ? 1 : 0;
    if (acc) begin
      m_addr = m_ptr;
      m_data = int'(data);
      m_ptr  = (m_ptr + 1) % DEPTH;
    end
    m_count = m_count + (acc ? 1 : 0) - (dec ? 1 : 0);
`ifdef FIFO_WR_OVF_STICKY_EN
    if (req && was_full) m_ovf = 1;
`else
    m_ovf = (req && was_full) ? 1 : 0;
`endif
    #1;
    checkOutput(tag);
  endtask

  // Assert reset away from the edge, verify outputs clear at once, then release
  task automatic doReset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    rd_inc = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    rst     = 1'b0;
    wr_req  = 1'b0;
    wr_data = '0;
    rd_inc  = 1'b0;
    modelReset();

    // Test 1: reset, three writes, RAM port one cycle late
    doReset("rst0");
    applyStimulus("t1.w0", 1'b1, 8'hA1, 1'b0);
    cmp("t1.addr0", int'(ram_waddr), 0);
    cmp("t1.data0", int'(ram_wdata), 'hA1);
    applyStimulus("t1.w1", 1'b1, 8'hA2, 1'b0);
    applyStimulus("t1.w2", 1'b1, 8'hA3, 1'b0);
    cmp("t1.data2", int'(ram_wdata), 'hA3);
    applyStimulus("t1.idle", 1'b0, 8'h00, 1'b0);
    cmp("t1.count", int'(count), 3);

    // Test 2: 16 back-to-back writes then a 17th rejected
    doReset("rst2");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("t2.fill", 1'b1, 8'(i + 8'h10), 1'b0);
      if (i == 13) cmp("t2.af14", int'(almost_full), 1);
      if (i == 12) cmp("t2.af13", int'(almost_full), 0);
    end
    cmp("t2.full16", int'(full), 1);
    applyStimulus("t2.over", 1'b1, 8'hEE, 1'b0);
    cmp("t2.ovf", int'(overflow), 1);
    cmp("t2.nowe", int'(ram_we), 0);
    cmp("t2.cnt16", int'(count), DEPTH);

    // Test 3: full with write and read in the same cycle, then wrap write
    applyStimulus("t3.both", 1'b1, 8'h55, 1'b1);
    cmp("t3.cnt15", int'(count), DEPTH - 1);
    cmp("t3.nofull", int'(full), 0);
    applyStimulus("t3.wrap", 1'b1, 8'h66, 1'b0);
    cmp("t3.addr0", int'(ram_waddr), 0);
    cmp("t3.cnt16", int'(count), DEPTH);
    applyStimulus("t3.idle", 1'b0, 8'h00, 1'b0);

    // Test 4: count 5, simultaneous write and read for 4 cycles
    doReset("rst4");
    for (int i = 0; i < 5; i++) applyStimulus("t4.pre", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("t4.both", 1'b1, 8'(8'hC0 + i), 1'b1);
      cmp("t4.we", int'(ram_we), 1);
      cmp("t4.cnt5", int'(count), 5);
    end

    // Test 5: read at empty, then reset in the middle of a burst
    doReset("rst5");
    applyStimulus("t5.rdempty", 1'b0, 8'h00, 1'b1);
    cmp("t5.cnt0", int'(count), 0);
    for (int i = 0; i < 3; i++) applyStimulus("t5.burst", 1'b1, 8'(8'h30 + i), 1'b0);
    wr_req = 1'b1;
    doReset("t5.midrst");
    applyStimulus("t5.first", 1'b1, 8'h77, 1'b0);
    cmp("t5.addr0", int'(ram_waddr), 0);

    // Test 6: overflow behaviour after leaving full
    doReset("rst6");
    for (int i = 0; i < DEPTH; i++) applyStimulus("t6.fill", 1'b1, 8'(i), 1'b0);
    applyStimulus("t6.rej1", 1'b1, 8'h01, 1'b0);
    applyStimulus("t6.rej2", 1'b1, 8'h02, 1'b0);
    applyStimulus("t6.drain", 1'b0, 8'h00, 1'b1);
    applyStimulus("t6.after", 1'b0, 8'h00, 1'b1);
`ifdef FIFO_WR_OVF_STICKY_EN
    cmp("t6.sticky", int'(overflow), 1);
`else
    cmp("t6.pulse", int'(overflow), 0);
`endif

    // Random traffic in phases biased toward filling, draining and balance
    doReset("rstR");
    for (int i = 0; i < 600; i++) begin
      int phase;
      int preq;
      int prd;
      phase = (i / 60) % 3;
      preq  = (phase == 0) ? 85 : (phase == 1) ? 20 : 55;
      prd   = (phase == 0) ? 20 : (phase == 1) ? 85 : 50;
      applyStimulus("rnd", 1'($urandom_range(99) < preq), 8'($urandom),
                    1'($urandom_range(99) < prd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
